// File: rtl/reward_writeback.sv
// reward_writeback: latches a multi-word reward record and writes it to memory
// one word per cycle, then holds done_wb until the upstream request drops.
module reward_writeback #(
  parameter int WORD_WIDTH = 16,
  parameter int N_WORDS = 5,
  parameter int unsigned BASE_ADDR = 'h0100,
  parameter int unsigned ADDR_STRIDE = 2
)(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           done_prev,
  input  logic [WORD_WIDTH*N_WORDS-1:0]  reward_data_in,
  output logic [WORD_WIDTH-1:0]          address,
  output logic                           wr_en,
  output logic [WORD_WIDTH-1:0]          mem_data_in,
  output logic                           busy,
  output logic                           done_wb
);
  localparam int IW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [WORD_WIDTH*N_WORDS-1:0] rec;
  logic [WORD_WIDTH-1:0] words [N_WORDS];
  logic last;
  assign last = idx == IW'(N_WORDS - 1);
  for (genvar i = 0; i < N_WORDS; i++) begin : g_word
    assign words[i] = rec[WORD_WIDTH*(N_WORDS-1-i) +: WORD_WIDTH];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE  ? (done_prev ? WRITE : IDLE) :
           state == WRITE ? (last ? DONE : WRITE) :
                            (done_prev ? DONE : IDLE);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rec <= '0;
      idx <= '0;
    end else if (state == IDLE && done_prev) begin
      rec <= reward_data_in;
      idx <= '0;
    end else if (state == WRITE && !last) begin
      idx <= idx + 1'b1;
    end
  // Outputs depend on registered state only; address wraps modulo 2^WORD_WIDTH.
  always_comb begin
    busy = state == WRITE;
    wr_en = busy;
    done_wb = state == DONE;
    address = busy ? WORD_WIDTH'(BASE_ADDR) + WORD_WIDTH'(ADDR_STRIDE) * WORD_WIDTH'(idx) : '0;
    mem_data_in = busy ? words[idx] : '0;
  end
endmodule

// File: tb/tb_reward_writeback.sv
// tb_reward_writeback: randomized and directed checks of reward_writeback
// against a write-queue reference model, at two base addresses (normal and wrapping).
module tb_reward_writeback;
  logic clock = 0, reset = 1, done_prev = 0;
  logic [79:0] data = '0;
  logic [15:0] addr_a, wd_a, addr_b, wd_b;
  logic wr_a, busy_a, dn_a, wr_b, busy_b, dn_b;
  int errors = 0, checks = 0;
  logic [15:0] q_data[$];
  int q_idx[$];
  bit done_m = 0;
  logic [15:0] mem [logic [15:0]];

  always #5 clock = ~clock;

  reward_writeback dut_a (.clock(clock), .reset(reset), .done_prev(done_prev), .reward_data_in(data),
    .address(addr_a), .wr_en(wr_a), .mem_data_in(wd_a), .busy(busy_a), .done_wb(dn_a));
  reward_writeback #(.BASE_ADDR('hFFFC)) dut_b (.clock(clock), .reset(reset), .done_prev(done_prev),
    .reward_data_in(data), .address(addr_b), .wr_en(wr_b), .mem_data_in(wd_b), .busy(busy_b), .done_wb(dn_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    bit w = q_data.size() > 0;
    logic [15:0] ea = w ? 16'(32'h0100 + 2 * q_idx[0]) : 16'h0;
    logic [15:0] eb = w ? 16'(32'hFFFC + 2 * q_idx[0]) : 16'h0;
    logic [15:0] ed = w ? q_data[0] : 16'h0;
    chk("wr_en_a", 32'(wr_a), 32'(w));
    chk("busy_a", 32'(busy_a), 32'(w));
    chk("done_a", 32'(dn_a), 32'(done_m));
    chk("addr_a", 32'(addr_a), 32'(ea));
    chk("data_a", 32'(wd_a), 32'(ed));
    chk("wr_en_b", 32'(wr_b), 32'(w));
    chk("done_b", 32'(dn_b), 32'(done_m));
    chk("addr_b", 32'(addr_b), 32'(eb));
    chk("data_b", 32'(wd_b), 32'(ed));
  endtask

  // Reference: a capture queues every word; one word retires per cycle.
  task automatic model_edge();
    if (q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_idx.pop_front());
      if (q_data.size() == 0) done_m = 1;
    end else if (done_m) begin
      if (!done_prev) done_m = 0;
    end else if (done_prev) begin
      for (int k = 0; k < 5; k++) begin
        q_data.push_back(data[79-16*k -: 16]);
        q_idx.push_back(k);
      end
    end
  endtask

  task automatic step(input bit dp, input logic [79:0] d);
    bit pw;
    logic [15:0] pa, pd;
    check_outs();
    pw = wr_a; pa = addr_a; pd = wd_a;
    done_prev = dp;
    data = d;
    @(posedge clock);
    if (pw) mem[pa] = pd;
    model_edge();
    @(negedge clock);
  endtask

  task automatic abort();
    reset = 1;
    #1;
    chk("rst_wr_a", 32'(wr_a), 0);
    chk("rst_wr_b", 32'(wr_b), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_data_a", 32'(wd_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(dn_a), 0);
    q_data.delete();
    q_idx.delete();
    done_m = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    logic [79:0] d1 = 80'h0011_2233_4455_6677_8899;
    logic [79:0] d2 = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
    #3;
    chk("reset_wr", 32'(wr_a), 0);
    chk("reset_done", 32'(dn_a), 0);
    chk("reset_addr_b", 32'(addr_b), 0);
    @(negedge clock);
    reset = 0;
    // basic burst, done held while done_prev high
    for (int i = 0; i < 9; i++) step(1, d1);
    chk("mem_0108", 32'(mem.exists(16'h0108) ? mem[16'h0108] : 16'h0), 32'h8899);
    chk("mem_0100", 32'(mem.exists(16'h0100) ? mem[16'h0100] : 16'h0), 32'h0011);
    // retrigger after one low cycle
    step(0, d1);
    for (int i = 0; i < 8; i++) step(1, d2);
    chk("mem_0104_new", 32'(mem.exists(16'h0104) ? mem[16'h0104] : 16'h0), 32'hCCCC);
    for (int i = 0; i < 2; i++) step(0, d2);
    // reset during the idx=2 write
    mem.delete();
    for (int i = 0; i < 3; i++) step(1, d1);
    chk("pre_abort_addr", 32'(addr_a), 32'h0104);
    abort();
    chk("abort_mem_0100", 32'(mem.exists(16'h0100) ? mem[16'h0100] : 16'h0), 32'h0011);
    chk("abort_mem_0102", 32'(mem.exists(16'h0102) ? mem[16'h0102] : 16'h0), 32'h2233);
    chk("abort_no_0104", 32'(mem.exists(16'h0104)), 0);
    for (int i = 0; i < 8; i++) step(1, d2);
    // input churn during idx=1
    for (int i = 0; i < 2; i++) step(0, d2);
    step(1, d1);
    step(1, d1);
    for (int i = 0; i < 8; i++) step(0, rnd80());
    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) abort();
      else step($urandom_range(0, 3) != 0, rnd80());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
